// File: rtl/friscv_lsu.sv
// Load/store unit: one request at a time through IDLE -> ISSUE -> (WAIT) -> RESP,
// steering store lanes/byte enables and extending load lanes from a sync-read dmem.
module friscv_lsu #(
  parameter int ARCH            = 32,
  parameter int DMEM_ADDR_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_store_i,
  input  logic [2:0]                 req_funct3_i,
  input  logic [ARCH-1:0]            req_addr_i,
  input  logic [ARCH-1:0]            req_wdata_i,
  input  logic [4:0]                 req_rd_i,
  output logic                       rsp_valid_o,
  output logic [ARCH-1:0]            rsp_rdata_o,
  output logic [4:0]                 rsp_rd_o,
  output logic                       rsp_err_o,
  output logic                       dmem_en_o,
  output logic                       dmem_we_o,
  output logic [3:0]                 dmem_be_o,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [ARCH-1:0]            dmem_wdata_o,
  input  logic [ARCH-1:0]            dmem_rdata_i,
  output logic [1:0]                 dbg_state_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Handshake: a request is taken on a rising edge where req_valid_i & req_ready_o;
  // ready depends on state only; responses are single-cycle pulses with no backpressure.
  state_t     state;
  logic       store_q;
  logic [2:0] funct3_q;
  logic [1:0] addr_q;
  logic [4:0] rd_q;

  logic            f3_ok;
  logic            misaligned;
  logic            req_err;
  logic [3:0]      st_be;
  logic [ARCH-1:0] st_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [ARCH-1:0] ld_ext;
  logic            unused_addr_hi;

  assign req_ready_o    = (state == IDLE);
  assign dbg_state_o    = state;
  assign unused_addr_hi = ^req_addr_i[ARCH-1:DMEM_ADDR_WIDTH];

  always_comb begin
    f3_ok = 1'b0;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !req_store_i;
      default:                f3_ok = 1'b0;
    endcase
    misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                 ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    req_err = !f3_ok || misaligned;
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        st_be    = 4'b0001 << req_addr_i[1:0];
        st_wdata = {(ARCH/8){req_wdata_i[7:0]}};
      end
      2'b01: begin
        st_be    = req_addr_i[1] ? 4'b1100 : 4'b0011;
        st_wdata = {(ARCH/16){req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata_i[{addr_q, 3'b000} +: 8];
    ld_half = dmem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_ext = {{(ARCH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(ARCH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(ARCH-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(ARCH-16){1'b0}}, ld_half};
      default: ld_ext = dmem_rdata_i;
    endcase
  end

  // All outputs default to zero each cycle so each one is live only in its own state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 2'b00;
      rd_q         <= 5'd0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      rsp_rd_o     <= 5'd0;
      rsp_err_o    <= 1'b0;
      dmem_en_o    <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_be_o    <= 4'b0000;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
    end else begin
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      rsp_rd_o     <= 5'd0;
      rsp_err_o    <= 1'b0;
      dmem_en_o    <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_be_o    <= 4'b0000;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            store_q  <= req_store_i;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i[1:0];
            rd_q     <= req_rd_i;
            if (req_err) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end else begin
              state       <= ISSUE;
              dmem_en_o   <= 1'b1;
              dmem_we_o   <= req_store_i;
              dmem_addr_o <= req_addr_i[DMEM_ADDR_WIDTH-1:0];
              if (req_store_i) begin
                dmem_be_o    <= st_be;
                dmem_wdata_o <= st_wdata;
              end
            end
          end
        end
        ISSUE: begin
          if (store_q) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          state       <= RESP;
          rsp_valid_o <= 1'b1;
          rsp_rdata_o <= ld_ext;
          rsp_rd_o    <= rd_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
